// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int unsigned SAMPLE_MID_LO = 7;
  localparam int unsigned SAMPLE_MID    = 8;
  localparam int unsigned SAMPLE_MID_HI = 9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned step;
    step = baud * os;
    return (clk_hz + step / 2) / step;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through FIFO with occupancy count and overrun pulse.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [LVL_W-1:0]  count_n;
  logic              pop_c;
  logic              full_c;
  logic              wr_en_c;
  logic              drop_c;

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  always_comb begin
    pop_c   = rd_valid && pop_ready;
    full_c  = (count == LVL_W'(DEPTH));
    wr_en_c = push && (!full_c || pop_c);
    drop_c  = push && full_c && !pop_c;
    count_n = count;
    if (wr_en_c && !pop_c)
      count_n = count + 1'b1;
    else if (!wr_en_c && pop_c)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en_c)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_n;
      rd_valid <= (count_n != '0);
      overrun  <= drop_c;
    end
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;
  assign level   = count;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, majority vote and receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          rs232_rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          framing_err,
  output logic                          overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t         state;
  rx_state_t         next_state;
  logic              rx_meta;
  logic              rx_s;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        sample_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              v_lo;
  logic              v_mid;
  logic              tick_c;
  logic              maj_c;
  logic              mid_hi_c;
  logic              wrap_c;
  logic              start_c;
  logic              push_c;
  logic              ferr_c;

  // Third vote is the live sample at the decision tick.
  always_comb begin
    tick_c   = (tick_cnt == TICK_W'(DIV - 1));
    maj_c    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);
    mid_hi_c = tick_c && (sample_cnt == 4'(SAMPLE_MID_HI));
    wrap_c   = tick_c && (sample_cnt == 4'd15);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
          start_c    = 1'b1;
        end
      end
      START: begin
        if (mid_hi_c && maj_c)
          next_state = IDLE;
        else if (wrap_c)
          next_state = DATA;
      end
      DATA: begin
        if (wrap_c && (bit_idx == 3'd7))
          next_state = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (mid_hi_c) begin
          if (maj_c) begin
            push_c     = 1'b1;
            next_state = IDLE;
          end else begin
            ferr_c     = 1'b1;
            next_state = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Synchroniser, tick/sample timing and deserialiser datapath.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      tick_cnt    <= '0;
      sample_cnt  <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      v_lo        <= 1'b1;
      v_mid       <= 1'b1;
      framing_err <= 1'b0;
    end else begin
      rx_meta <= rs232_rx;
      rx_s    <= rx_meta;
      if (start_c || tick_c)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
      if (start_c)
        sample_cnt <= '0;
      else if (tick_c)
        sample_cnt <= sample_cnt + 4'd1;
      if (tick_c && (sample_cnt == 4'(SAMPLE_MID_LO)))
        v_lo <= rx_s;
      if (tick_c && (sample_cnt == 4'(SAMPLE_MID)))
        v_mid <= rx_s;
      if ((state == DATA) && mid_hi_c)
        shift <= {maj_c, shift[7:1]};
      if (start_c)
        bit_idx <= '0;
      else if ((state == DATA) && wrap_c)
        bit_idx <= bit_idx + 3'd1;
      framing_err <= ferr_c;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (push_c),
    .push_data (shift),
    .pop_ready (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (fifo_level),
    .overrun   (overrun_err)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table, random traffic against a
// queue model, and hand-written overrun / full-with-pop / reset sequences.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ   = 50000000;
  localparam int unsigned BAUD     = 781000;
  localparam int unsigned DEPTH    = 16;
  localparam int          DIV      = 4;
  localparam int          BIT      = 16 * DIV;
  // Stop-bit decision tick is the 154th tick after the start edge reaches the
  // FSM (2 sync cycles + 1 state cycle); the byte is written on that edge.
  localparam int          PUSH_IDX = 2 + (9 * 16 + 10) * DIV;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       rs232_rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       framing_err;
  logic       overrun_err;
  logic [4:0] fifo_level;

  always #5 clk_clk = ~clk_clk;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .rs232_rx    (rs232_rx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         stop_len;
    int         glitch;
    int         exp_pops;
    int         exp_ferr;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         oerr_cnt = 0;
  int         pop_cnt = 0;
  int         oerr_frame = -1;
  int         cur_frame = 0;
  int         cyc = 0;
  int         first_valid_cyc = 0;
  bit         arm_valid = 0;
  logic [7:0] last_pop = 8'h00;
  int         rdy_mode = 0;
  int         ready_at = -1;
  int         fidx = 0;
  bit         pend_push = 0;
  logic [7:0] pend_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Output monitor, sampled just after the falling edge.
  always @(negedge clk_clk) begin
    #1;
    cyc++;
    if (framing_err) ferr_cnt++;
    if (overrun_err) begin
      oerr_cnt++;
      oerr_frame = cur_frame;
    end
    if (framing_err && overrun_err) check("err_exclusive", 1, 0);
    if (arm_valid && rd_valid) begin
      first_valid_cyc = cyc;
      arm_valid = 0;
    end
    if (rd_valid && rd_ready && !reset_reset) begin
      pop_cnt++;
      last_pop = rd_data;
      if (exp_q.size() == 0) check("spurious_pop", int'(rd_data), -1);
      else check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
    end
  end

  // Model a completed frame: accepted unless full with no pop this cycle.
  task automatic model_push();
    pend_push = 0;
    if (exp_q.size() < DEPTH || (rd_ready && exp_q.size() > 0))
      exp_q.push_back(pend_data);
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rs232_rx = v;
      if (rdy_mode == 1) rd_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) rd_ready = (fidx == ready_at);
      if (pend_push && fidx == PUSH_IDX) model_push();
      fidx++;
      @(negedge clk_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    fidx = 0;
    pend_push = stop;
    pend_data = d;
    drive(1'b0, BIT);
    for (int b = 0; b < 8; b++) drive(d[b], BIT);
    drive(stop, stop_len);
    rs232_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    rdy_mode = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 100 && fifo_level != 5'd0; i++) drive(1'b1, 1);
    drive(1'b1, 2);
    check({name, "_drain_level"}, int'(fifo_level), 0);
    check({name, "_drain_model"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int   p0, f0, o0, st;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, BIT,  0,       1, 0};
    vecs[1] = '{8'h00, 1'b1, BIT,  BIT / 4, 0, 0};
    vecs[2] = '{8'h3C, 1'b0, 3000, 0,       0, 1};
    vecs[3] = '{8'h81, 1'b1, BIT,  0,       1, 0};
    vecs[4] = '{8'h00, 1'b1, BIT,  0,       1, 0};
    vecs[5] = '{8'hFF, 1'b1, BIT,  0,       1, 0};
    vecs[6] = '{8'h7E, 1'b0, BIT,  0,       0, 1};

    rs232_rx = 1'b1;
    rd_ready = 1'b0;
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_framing", int'(framing_err), 0);
    check("rst_overrun", int'(overrun_err), 0);
    reset_reset = 1'b0;
    drive(1'b1, 2 * BIT);

    // Frame table with consumer always ready.
    for (int i = 0; i < 7; i++) begin
      p0 = pop_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
      rdy_mode = 0;
      rd_ready = 1'b1;
      st = 0;
      if (vecs[i].glitch > 0) begin
        fidx = 0;
        pend_push = 0;
        drive(1'b0, vecs[i].glitch);
      end else begin
        arm_valid = (vecs[i].exp_pops > 0);
        st = cyc + 1;
        send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop_len);
      end
      drive(1'b1, 2 * BIT);
      check($sformatf("vec%0d_pops", i), pop_cnt - p0, vecs[i].exp_pops);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_oerr", i), oerr_cnt - o0, 0);
      check($sformatf("vec%0d_level", i), int'(fifo_level), 0);
      if (vecs[i].exp_pops > 0)
        check_rng($sformatf("vec%0d_latency", i), first_valid_cyc - st, 9 * BIT, 10 * BIT - 1);
      arm_valid = 0;
    end

    // Random bytes, random gaps, random consumer stalls.
    f0 = ferr_cnt; o0 = oerr_cnt; p0 = pop_cnt;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1'b1, BIT);
      drive(1'b1, $urandom_range(0, BIT / 2));
    end
    drain("random");
    check("random_pops", pop_cnt - p0, 8);
    check("random_ferr", ferr_cnt - f0, 0);
    check("random_oerr", oerr_cnt - o0, 0);

    // 17 back-to-back bytes with no consumer: last one overruns.
    rdy_mode = 0;
    rd_ready = 1'b0;
    o0 = oerr_cnt; f0 = ferr_cnt;
    for (int i = 0; i <= 16; i++) begin
      cur_frame = i;
      send_frame(8'(i), 1'b1, BIT);
    end
    drive(1'b1, BIT);
    check("ovr_level", int'(fifo_level), 16);
    check("ovr_count", oerr_cnt - o0, 1);
    check("ovr_frame", oerr_frame, 16);
    check("ovr_ferr", ferr_cnt - f0, 0);
    p0 = pop_cnt;
    drain("ovr");
    check("ovr_pops", pop_cnt - p0, 16);
    check("ovr_last", int'(last_pop), 8'h0F);

    // Full FIFO with a pop in exactly the push cycle of 0x55.
    rd_ready = 1'b0;
    cur_frame = 100;
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, BIT);
    drive(1'b1, BIT);
    check("full_level", int'(fifo_level), 16);
    o0 = oerr_cnt; p0 = pop_cnt;
    rdy_mode = 2;
    ready_at = PUSH_IDX;
    send_frame(8'h55, 1'b1, BIT);
    rdy_mode = 0;
    rd_ready = 1'b0;
    drive(1'b1, BIT);
    check("fullpop_oerr", oerr_cnt - o0, 0);
    check("fullpop_level", int'(fifo_level), 16);
    check("fullpop_pops", pop_cnt - p0, 1);
    drain("fullpop");
    check("fullpop_last", int'(last_pop), 8'h55);

    // Reset during data bit 4 of 0xF0 with bytes already queued.
    rd_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT);
    send_frame(8'h22, 1'b1, BIT);
    drive(1'b1, BIT);
    check("prerst_level", int'(fifo_level), 2);
    d = 8'hF0;
    fidx = 0;
    pend_push = 0;
    f0 = ferr_cnt; o0 = oerr_cnt;
    drive(1'b0, BIT);
    for (int b = 0; b < 4; b++) drive(d[b], BIT);
    drive(d[4], BIT / 2);
    reset_reset = 1'b1;
    exp_q.delete();
    drive(d[4], 1);
    reset_reset = 1'b0;
    check("midrst_rd_valid", int'(rd_valid), 0);
    check("midrst_rd_data", int'(rd_data), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_framing", int'(framing_err), 0);
    check("midrst_overrun", int'(overrun_err), 0);
    rd_ready = 1'b1;
    p0 = pop_cnt;
    drive(d[4], BIT / 2 - 1);
    for (int b = 5; b < 8; b++) drive(d[b], BIT);
    drive(1'b1, 3 * BIT);
    check("postrst_pops", pop_cnt - p0, 0);
    check("postrst_level", int'(fifo_level), 0);
    check("postrst_ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1, BIT);
    drive(1'b1, 2 * BIT);
    check("postrst_frame_pops", pop_cnt - p0, 1);
    check("postrst_frame_data", int'(last_pop), 8'h5A);
    check("postrst_oerr", oerr_cnt - o0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
